cpu5_ifu: RTL and testbench
===========================

CPU5_IFU -- requirements
Module: cpu5_ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 resetn  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 imem_req_valid  output  1  SHALL flag a fetch request.
REQ-005 imem_req_ready  input  1  SHALL flag that memory accepts the request this cycle.
REQ-006 imem_req_addr  output  32  SHALL carry the fetch address.
REQ-007 imem_rsp_valid  input  1  SHALL flag returned instruction data; it has no backpressure.
REQ-008 imem_rsp_data  input  32  SHALL carry the returned instruction word.
REQ-009 redirect_valid  input  1  SHALL flag a taken branch or jump from execute.
REQ-010 redirect_pc  input  32  SHALL carry the redirect target.
REQ-011 id_ready  input  1  SHALL flag that decode consumes the IF/ID entry this cycle.
REQ-012 id_valid, id_instr[31:0], id_pc[31:0]  outputs SHALL form the IF/ID pipeline register.
REQ-013 id_op[6:0], id_funct3[2:0], id_funct7[6:0]  outputs SHALL equal id_instr[6:0], [14:12], [31:25] combinationally.
REQ-014 fetch_misalign  output  1  SHALL flag a sticky misaligned-redirect fault.

Function
REQ-015 FSM states: IDLE, REQ, WAIT, HOLD; exactly one request outstanding at any time.
REQ-016 IDLE SHALL go to REQ unconditionally on the first clock after reset release.
REQ-017 In REQ, imem_req_valid=1 and imem_req_addr=pc.
REQ-018 In REQ, on imem_req_ready: fetch_pc<=pc, pc<=pc+4 (mod 2^32), state->WAIT.
REQ-019 In WAIT, on imem_rsp_valid with the IF/ID register free: load id_instr=imem_rsp_data, id_pc=fetch_pc, id_valid=1, then go to REQ.
- "Free" means id_valid=0 or id_ready=1.
REQ-020 In WAIT, on imem_rsp_valid with IF/ID occupied and id_ready=0: capture the data into a one-entry hold buffer, state->HOLD.
REQ-021 In HOLD, on id_ready: move the buffer into IF/ID, state->REQ.
- Uncaptured data SHALL never be lost or duplicated.
REQ-022 When id_ready=1 and nothing loads this cycle, id_valid SHALL clear next cycle.
- id_instr and id_pc hold their last values.
REQ-023 Steady-state throughput with a zero-wait memory SHALL be one instruction per two cycles.
- First id_valid SHALL appear 3 cycles after reset release (IDLE, REQ, WAIT).
REQ-024 redirect_valid SHALL take priority over every other event.
- Actions: pc<=redirect_pc, id_valid<=0, hold buffer discarded.
REQ-025 On redirect in IDLE, REQ without acceptance, or HOLD: state->REQ.
REQ-026 On redirect in REQ with imem_req_ready=1 in the same cycle: state->WAIT with kill=1.
REQ-027 On redirect in WAIT with imem_rsp_valid=0: stay in WAIT with kill=1.
REQ-028 On redirect in WAIT with imem_rsp_valid=1: drop the response, state->REQ.
REQ-029 In WAIT with kill=1, the response SHALL be discarded, kill cleared, and state->REQ.
REQ-030 A killed response SHALL never reach IF/ID.

Reset
REQ-031 Asynchronous assertion of resetn SHALL force the following state:
- pc=RESET_PC, fetch_pc=0, state=IDLE, kill=0, hold buffer empty.
- id_valid=0, id_instr=32'h0000_0013 (NOP), id_pc=0.
- imem_req_valid=0, fetch_misalign=0.
REQ-032 Reset mid-transaction SHALL abandon any outstanding request.
- Any response arriving before the first post-reset REQ SHALL be ignored.

Configuration
REQ-033 Macro CPU5_IFU_MISALIGN_CHK_EN defined:
- A redirect with redirect_pc[1:0]!=0 sets fetch_misalign=1 and state->IDLE-halt.
- While halted, no further requests are issued and id_valid=0 until reset.
REQ-034 Macro CPU5_IFU_MISALIGN_CHK_EN undefined:
- redirect_pc[1:0] is forced to 2'b00.
- fetch_misalign is tied 0.

Verification
REQ-035 Reset release, RESET_PC=0, zero-wait memory returning 32'h00500093 at addr 0 -> id_valid=1, id_pc=0, id_op=7'b0010011, id_funct3=3'b000 on cycle 3.
REQ-036 id_ready=0 for 5 cycles during streaming -> IF/ID and the hold buffer keep 2 instructions; on release, pc sequence 0x8, 0xC continues with no gap or duplicate.
REQ-037 redirect_valid=1, redirect_pc=0x100 while in WAIT, response arrives 2 cycles later -> response dropped; next request addr=0x100; id_pc never shows the stale address.
REQ-038 redirect and imem_req_ready in the same REQ cycle, redirect_pc=0x40 -> stale response discarded; next imem_req_addr=0x40.
REQ-039 pc=32'hFFFF_FFFC fetched -> next imem_req_addr=32'h0000_0000.
REQ-040 redirect_pc=0x102 -> with macro: fetch_misalign=1 and imem_req_valid stays 0; without macro: next imem_req_addr=0x100.

Source files
------------

// File: rtl/cpu5_ifu.sv
// Instruction fetch unit: one outstanding imem request, IF/ID register with a one-entry skid buffer.
// Optional misaligned-redirect halt is enabled by defining CPU5_IFU_MISALIGN_CHK_EN.
module cpu5_ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [6:0]  id_op,
    output logic [2:0]  id_funct3,
    output logic [6:0]  id_funct7,
    output logic        fetch_misalign
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_fetch_pc, w_fetch_pc_nxt;
    logic        r_kill, w_kill_nxt;
    logic [31:0] r_hold_instr, w_hold_nxt;
    logic        r_id_valid, w_id_valid_nxt;
    logic [31:0] r_id_instr, w_id_instr_nxt;
    logic [31:0] r_id_pc, w_id_pc_nxt;
    logic        w_free;
    logic        w_halted;
    logic [31:0] w_redirect_target;

`ifdef CPU5_IFU_MISALIGN_CHK_EN
    logic        r_misalign, w_misalign_nxt;
    assign w_halted          = r_misalign;
    assign w_redirect_target = redirect_pc;
    assign fetch_misalign    = r_misalign;
`else
    logic        w_unused_redirect_lsb;
    assign w_unused_redirect_lsb = ^redirect_pc[1:0];
    assign w_halted          = 1'b0;
    assign w_redirect_target = {redirect_pc[31:2], 2'b00};
    assign fetch_misalign    = 1'b0;
`endif

    assign w_free         = !r_id_valid || id_ready;
    assign imem_req_valid = (r_state == S_REQ);
    assign imem_req_addr  = r_pc;
    assign id_valid       = r_id_valid;
    assign id_instr       = r_id_instr;
    assign id_pc          = r_id_pc;
    assign id_op          = r_id_instr[6:0];
    assign id_funct3      = r_id_instr[14:12];
    assign id_funct7      = r_id_instr[31:25];

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_fetch_pc_nxt = r_fetch_pc;
        w_kill_nxt     = r_kill;
        w_hold_nxt     = r_hold_instr;
        w_id_valid_nxt = r_id_valid && !id_ready;
        w_id_instr_nxt = r_id_instr;
        w_id_pc_nxt    = r_id_pc;
`ifdef CPU5_IFU_MISALIGN_CHK_EN
        w_misalign_nxt = r_misalign;
`endif
        if (w_halted) begin
            w_state_nxt    = S_IDLE;
            w_id_valid_nxt = 1'b0;
        end else if (redirect_valid) begin
            w_pc_nxt       = w_redirect_target;
            w_id_valid_nxt = 1'b0;
            case (r_state)
                S_REQ: begin
                    // An accepted request is already in flight; its response must be killed.
                    if (imem_req_ready) begin
                        w_state_nxt = S_WAIT;
                        w_kill_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        w_state_nxt = S_REQ;
                        w_kill_nxt  = 1'b0;
                    end else begin
                        w_kill_nxt  = 1'b1;
                    end
                end
                default: w_state_nxt = S_REQ;
            endcase
`ifdef CPU5_IFU_MISALIGN_CHK_EN
            if (redirect_pc[1:0] != 2'b00) begin
                w_misalign_nxt = 1'b1;
                w_state_nxt    = S_IDLE;
                w_kill_nxt     = 1'b0;
            end
`endif
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_REQ;
                S_REQ: begin
                    if (imem_req_ready) begin
                        w_fetch_pc_nxt = r_pc;
                        w_pc_nxt       = r_pc + 32'd4;
                        w_state_nxt    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (r_kill) begin
                            w_kill_nxt  = 1'b0;
                            w_state_nxt = S_REQ;
                        end else if (w_free) begin
                            w_id_instr_nxt = imem_rsp_data;
                            w_id_pc_nxt    = r_fetch_pc;
                            w_id_valid_nxt = 1'b1;
                            w_state_nxt    = S_REQ;
                        end else begin
                            w_hold_nxt  = imem_rsp_data;
                            w_state_nxt = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (id_ready) begin
                        w_id_instr_nxt = r_hold_instr;
                        w_id_pc_nxt    = r_fetch_pc;
                        w_id_valid_nxt = 1'b1;
                        w_state_nxt    = S_REQ;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_fetch_pc   <= 32'd0;
            r_kill       <= 1'b0;
            r_hold_instr <= NOP;
            r_id_valid   <= 1'b0;
            r_id_instr   <= NOP;
            r_id_pc      <= 32'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_fetch_pc   <= w_fetch_pc_nxt;
            r_kill       <= w_kill_nxt;
            r_hold_instr <= w_hold_nxt;
            r_id_valid   <= w_id_valid_nxt;
            r_id_instr   <= w_id_instr_nxt;
            r_id_pc      <= w_id_pc_nxt;
        end
    end

`ifdef CPU5_IFU_MISALIGN_CHK_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misalign_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_cpu5_ifu.sv
// Self-checking bench for cpu5_ifu: memory model, in-order scoreboard of accepted fetches,
// table-driven decode-field vectors and hand-written redirect/stall/reset sequences.
module tb_cpu5_ifu;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        resetn;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [6:0]  id_op;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;
    logic        fetch_misalign;

    cpu5_ifu #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_op          (id_op),
        .id_funct3      (id_funct3),
        .id_funct7      (id_funct7),
        .fetch_misalign (fetch_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } expT;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
    } vecT;

    expT         expQ[$];
    logic [31:0] consumedPcs[$];
    vecT         vecs[5];
    logic [31:0] memArr [0:63];
    int          checks = 0;
    int          errors = 0;
    int          consumedCount = 0;
    logic        pending = 1'b0;
    int          pendCnt = 0;
    logic [31:0] pendAddr = 32'd0;
    int          rspDelay = 0;
    logic [31:0] expPc = RESET_PC;

    function automatic logic [31:0] memRead(input logic [31:0] a);
        if (a[31:8] == 24'h0) return memArr[a[7:2]];
        return {a[31:8], 8'h13};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs at the negedge, account for what the next posedge does.
    task automatic applyStimulus(input logic rdy, input logic idr, input logic rv, input logic [31:0] rpc);
        expT e;
        imem_req_ready = rdy;
        id_ready       = idr;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hDEAD_BEEF;
        if (pending) begin
            if (pendCnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = memRead(pendAddr);
                pending        = 1'b0;
            end else begin
                pendCnt--;
            end
        end
        if (id_valid && idr) begin
            consumedCount++;
            consumedPcs.push_back(id_pc);
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL consume_unexpected: got id_pc %h expected no entry", id_pc);
            end else begin
                e = expQ.pop_front();
                checkOutput("consume_pc", id_pc, e.pc);
                checkOutput("consume_instr", id_instr, e.instr);
            end
        end
        if (imem_req_valid && rdy) begin
            if (pending) begin
                checks++;
                errors++;
                $display("[TB] FAIL outstanding: got second request %h expected none", imem_req_addr);
            end
            checkOutput("req_addr", imem_req_addr, expPc);
            pending  = 1'b1;
            pendCnt  = rspDelay;
            pendAddr = imem_req_addr;
            expQ.push_back('{imem_req_addr, memRead(imem_req_addr)});
            expPc = expPc + 32'd4;
        end
        if (rv) begin
            expQ.delete();
            expPc = {rpc[31:2], 2'b00};
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic waitReq(input string name);
        int n = 0;
        while (!imem_req_valid && n < 40) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
            n++;
        end
        if (!imem_req_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got no request expected imem_req_valid=1", name);
        end
    endtask

    task automatic waitIdValid(input string name);
        int n = 0;
        while (!id_valid && n < 40) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
            n++;
        end
        if (!id_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got id_valid=0 expected 1", name);
        end
    endtask

    // Asynchronous reset mid-cycle; any pending memory response is deliberately left in flight.
    task automatic doReset(input string name);
        #2;
        resetn         = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
        #1;
        checkBit({name, "_rst_req_valid"}, imem_req_valid, 1'b0);
        checkBit({name, "_rst_id_valid"}, id_valid, 1'b0);
        checkOutput({name, "_rst_id_instr"}, id_instr, 32'h0000_0013);
        checkOutput({name, "_rst_id_pc"}, id_pc, 32'd0);
        checkBit({name, "_rst_misalign"}, fetch_misalign, 1'b0);
        expQ.delete();
        expPc = RESET_PC;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got time limit expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        vecs[0] = '{32'h00, 32'h0050_0093, 7'h13, 3'd0, 7'h00};
        vecs[1] = '{32'h04, 32'h4020_8133, 7'h33, 3'd0, 7'h20};
        vecs[2] = '{32'h08, 32'h0020_A023, 7'h23, 3'd2, 7'h00};
        vecs[3] = '{32'h0C, 32'hFE5F_F06F, 7'h6F, 3'd7, 7'h7F};
        vecs[4] = '{32'h10, 32'h0000_C463, 7'h63, 3'd4, 7'h00};
        for (int i = 0; i < 64; i++) memArr[i] = {12'(i), 20'h00013};
        for (int i = 0; i < 5; i++) memArr[i] = vecs[i].instr;

        resetn = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        id_ready = 1'b0;

        @(negedge clk);
        checkBit("reset_req_valid", imem_req_valid, 1'b0);
        checkBit("reset_id_valid", id_valid, 1'b0);
        checkOutput("reset_id_instr", id_instr, 32'h0000_0013);
        checkOutput("reset_id_pc", id_pc, 32'd0);
        checkBit("reset_misalign", fetch_misalign, 1'b0);
        @(negedge clk);
        resetn = 1'b1;

        // First instruction latency: IDLE, REQ, WAIT.
        checkBit("idle_no_req", imem_req_valid, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        checkBit("first_req_valid", imem_req_valid, 1'b1);
        checkOutput("first_req_addr", imem_req_addr, RESET_PC);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        checkBit("cycle2_no_id", id_valid, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        checkBit("cycle3_id_valid", id_valid, 1'b1);
        checkOutput("cycle3_id_pc", id_pc, 32'd0);
        checkOutput("cycle3_id_op", {25'd0, id_op}, 32'h13);
        checkOutput("cycle3_id_funct3", {29'd0, id_funct3}, 32'd0);

        // Decode-field vectors streamed back to back.
        for (int i = 0; i < 5; i++) begin
            int n = 0;
            while (!(id_valid && id_pc == vecs[i].pc) && n < 40) begin
                applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
                n++;
            end
            checkBit("vec_valid", id_valid, 1'b1);
            checkOutput("vec_pc", id_pc, vecs[i].pc);
            checkOutput("vec_instr", id_instr, vecs[i].instr);
            checkOutput("vec_op", {25'd0, id_op}, {25'd0, vecs[i].op});
            checkOutput("vec_funct3", {29'd0, id_funct3}, {29'd0, vecs[i].f3});
            checkOutput("vec_funct7", {25'd0, id_funct7}, {25'd0, vecs[i].f7});
        end

        // Zero-wait memory: one instruction every two cycles.
        base = consumedCount;
        repeat (20) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        checkOutput("throughput", 32'(consumedCount - base), 32'd10);

        // Decode stall fills IF/ID and the hold buffer, then drains in order.
        doReset("stall");
        waitIdValid("stall_first");
        checkOutput("stall_first_pc", id_pc, 32'd0);
        repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        checkBit("stall_id_valid", id_valid, 1'b1);
        checkOutput("stall_id_pc", id_pc, 32'd0);
        checkBit("stall_no_req", imem_req_valid, 1'b0);
        consumedPcs.delete();
        begin
            int n = 0;
            while (consumedPcs.size() < 4 && n < 40) begin
                applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
                n++;
            end
        end
        checkOutput("drain_count", 32'(consumedPcs.size()), 32'd4);
        for (int k = 0; k < 4 && k < consumedPcs.size(); k++)
            checkOutput("drain_pc", consumedPcs[k], 32'(4 * k));

        // Redirect while waiting; the response arrives two cycles later and must be dropped.
        waitReq("r037_pre");
        rspDelay = 2;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h100);
        checkBit("r037_id_cleared", id_valid, 1'b0);
        checkBit("r037_wait_held", imem_req_valid, 1'b0);
        waitReq("r037");
        checkOutput("r037_req_addr", imem_req_addr, 32'h100);
        checkBit("r037_no_stale", id_valid, 1'b0);
        rspDelay = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        waitIdValid("r037_load");
        checkOutput("r037_id_pc", id_pc, 32'h100);

        // Redirect in the same cycle the request is accepted.
        waitReq("r038_pre");
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h40);
        checkBit("r038_waiting", imem_req_valid, 1'b0);
        waitReq("r038");
        checkOutput("r038_req_addr", imem_req_addr, 32'h40);
        checkBit("r038_no_stale", id_valid, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        waitIdValid("r038_load");
        checkOutput("r038_id_pc", id_pc, 32'h40);
        checkOutput("r038_id_instr", id_instr, memRead(32'h40));

        // PC wraps from the top of the address space.
        waitReq("wrap_pre");
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        checkBit("wrap_req_valid", imem_req_valid, 1'b1);
        checkOutput("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        waitReq("wrap");
        checkOutput("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
        checkOutput("wrap_next_addr", imem_req_addr, 32'd0);

        // Reset while a response is still in flight; it lands during IDLE and is ignored.
        waitReq("r032_pre");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        doReset("r032");
        checkBit("r032_idle", imem_req_valid, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        checkBit("r032_stale_ignored", id_valid, 1'b0);
        checkBit("r032_req_valid", imem_req_valid, 1'b1);
        checkOutput("r032_req_addr", imem_req_addr, RESET_PC);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        waitIdValid("r032_load");
        checkOutput("r032_id_pc", id_pc, RESET_PC);
        checkOutput("r032_id_instr", id_instr, vecs[0].instr);

        // Misaligned redirect target.
        waitReq("mis_pre");
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h102);
`ifdef CPU5_IFU_MISALIGN_CHK_EN
        checkBit("mis_flag", fetch_misalign, 1'b1);
        begin
            int bad = 0;
            repeat (6) begin
                if (imem_req_valid || id_valid) bad++;
                applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
            end
            applyStimulus(1'b1, 1'b1, 1'b1, 32'h200);
            if (imem_req_valid || id_valid) bad++;
            checkOutput("mis_halted", 32'(bad), 32'd0);
        end
        checkBit("mis_sticky", fetch_misalign, 1'b1);
`else
        checkBit("mis_flag", fetch_misalign, 1'b0);
        checkBit("mis_req_valid", imem_req_valid, 1'b1);
        checkOutput("mis_req_addr", imem_req_addr, 32'h100);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
